// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: funct codes, special op codes and the
// multi-cycle sequencer state type.
package alu_ctrl_pkg;

  // R-type funct field values
  localparam logic [5:0] FunctSrl   = 6'd2;
  localparam logic [5:0] FunctMfhi  = 6'd16;
  localparam logic [5:0] FunctMflo  = 6'd18;
  localparam logic [5:0] FunctMultu = 6'd25;
  localparam logic [5:0] FunctDivu  = 6'd27;
  localparam logic [5:0] FunctAdd   = 6'd32;
  localparam logic [5:0] FunctSub   = 6'd34;
  localparam logic [5:0] FunctAnd   = 6'd36;
  localparam logic [5:0] FunctOr    = 6'd37;
  localparam logic [5:0] FunctSlt   = 6'd42;

  // Control codes that are not funct values
  localparam logic [5:0] OpNop      = 6'h00;
  localparam logic [5:0] OpHiloOpen = 6'h3F;

  typedef enum logic [1:0] {
    StIdle,
    StDivRun,
    StMulRun,
    StWb
  } seq_state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational funct classifier shared by the op sequencer and hazard unit.
// Optional feature macro: ALU_SEQ_MULTU_EN (MULTU becomes a supported
// multi-cycle op; otherwise it is reported as unsupported).
module alu_funct_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic       supported,
  output logic       multi_cycle,
  output logic       is_mul
);

  // Classify funct into supported / multi-cycle / multiplier
  always_comb begin
    supported   = 1'b0;
    multi_cycle = 1'b0;
    is_mul      = 1'b0;
    case (funct)
      FunctAnd, FunctOr, FunctAdd, FunctSub, FunctSlt,
      FunctSrl, FunctMfhi, FunctMflo: begin
        supported = 1'b1;
      end
      FunctDivu: begin
        supported   = 1'b1;
        multi_cycle = 1'b1;
      end
`ifdef ALU_SEQ_MULTU_EN
      FunctMultu: begin
        supported   = 1'b1;
        multi_cycle = 1'b1;
        is_mul      = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// EX-stage ALU control decoder with a multi-cycle sequencer: registers
// per-unit control codes, starts the divider (and optionally multiplier),
// counts its iterations while holding issue, then strobes the HiLo write.
// Optional feature macro: ALU_SEQ_MULTU_EN (adds MULTU sequencing via MUL_RUN).
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] funct,
  input  logic       valid,
  input  logic       flush,
  output logic [5:0] op_alu,
  output logic [5:0] op_sht,
  output logic [5:0] op_div,
  output logic [5:0] op_mux,
  output logic       unit_start,
  output logic       busy,
  output logic       hilo_we,
  output logic       illegal
);

  localparam int unsigned MaxCycles = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MaxCycles) + 1;

  localparam logic [CNT_W-1:0] DivLast = CNT_W'(DIV_CYCLES - 1);
`ifdef ALU_SEQ_MULTU_EN
  localparam logic [CNT_W-1:0] MulLast = CNT_W'(MUL_CYCLES - 1);
`endif

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [5:0]       op_q;
  logic             unit_start_q;
  logic             busy_q;
  logic             hilo_we_q;
  logic             illegal_q;

  logic dec_supported;
  logic dec_multi;
  logic dec_is_mul;
  logic accept;

  alu_funct_decode u_decode (
    .funct      (funct),
    .supported  (dec_supported),
    .multi_cycle(dec_multi),
    .is_mul     (dec_is_mul)
  );

`ifndef ALU_SEQ_MULTU_EN
  // No multiplier sequencing in this build; decoder never raises is_mul
  logic unused_is_mul;
  assign unused_is_mul = dec_is_mul;
`endif

  assign accept = valid & ~busy_q & ~flush;

  // FSM, iteration counter and registered control outputs
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      // flush aborts exactly like reset, so no HiLo write leaks out
      state_q      <= StIdle;
      cnt_q        <= '0;
      op_q         <= OpNop;
      unit_start_q <= 1'b0;
      busy_q       <= 1'b0;
      hilo_we_q    <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      op_q         <= OpNop;
      unit_start_q <= 1'b0;
      hilo_we_q    <= 1'b0;
      illegal_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q  <= '0;
          busy_q <= 1'b0;
          if (accept) begin
            if (!dec_supported) begin
              illegal_q <= 1'b1;
            end else begin
              op_q <= funct;
              if (dec_multi) begin
                unit_start_q <= 1'b1;
                busy_q       <= 1'b1;
`ifdef ALU_SEQ_MULTU_EN
                state_q      <= dec_is_mul ? StMulRun : StDivRun;
`else
                state_q      <= StDivRun;
`endif
              end
            end
          end
        end
        StDivRun: begin
          busy_q <= 1'b1;
          if (cnt_q == DivLast) begin
            state_q   <= StWb;
            op_q      <= OpHiloOpen;
            hilo_we_q <= 1'b1;
          end else begin
            op_q  <= FunctDivu;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef ALU_SEQ_MULTU_EN
        StMulRun: begin
          busy_q <= 1'b1;
          if (cnt_q == MulLast) begin
            state_q   <= StWb;
            op_q      <= OpHiloOpen;
            hilo_we_q <= 1'b1;
          end else begin
            op_q  <= FunctMultu;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        StWb: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign op_alu     = op_q;
  assign op_sht     = op_q;
  assign op_div     = op_q;
  assign op_mux     = op_q;
  assign unit_start = unit_start_q;
  assign busy       = busy_q;
  assign hilo_we    = hilo_we_q;
  assign illegal    = illegal_q;

endmodule
